// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: routes one cell, optionally pulses injection, then times
// readout to threshold. One command per transaction; routing is held from ROUTE through MEAS.
module fg_prog_sequencer #(
  parameter int ISL_BITS = 1,
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 3,
  parameter int PULSE_W  = 16,
  parameter int SETTLE_W = 8,
  parameter int MEAS_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ISL_BITS-1:0]      cmd_island,
  input  logic [ROW_BITS-1:0]      cmd_row,
  input  logic [COL_BITS-1:0]      cmd_col,
  input  logic                     cmd_op,
  input  logic [PULSE_W-1:0]       cmd_pulse,
  input  logic [SETTLE_W-1:0]      cmd_settle,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [MEAS_W-1:0]        rsp_count,
  output logic                     rsp_timeout,
  output logic [(2**ISL_BITS)-1:0] island_en,
  output logic [ROW_BITS-1:0]      dec_v_addr,
  output logic [COL_BITS-1:0]      dec_h_addr,
  output logic                     gate_mux_en,
  output logic                     drain_sel_en,
  output logic                     prog_sw_en,
  output logic                     vinj_pulse,
  output logic                     meas_en,
  input  logic                     comp_in
);
  localparam int ISL_N = 2**ISL_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_ROUTE, S_PULSE, S_SWAP, S_MEAS, S_RELEASE, S_RESP
  } state_t;

  state_t                state;
  logic                  comp_meta, comp_s;
  logic                  op_q;
  logic                  tout_q;
  logic [PULSE_W-1:0]    pulse_cnt;
  logic [SETTLE_W-1:0]   settle_q, settle_cnt;
  logic [MEAS_W-1:0]     meas_cnt;
  logic [ISL_N-1:0]      isl_onehot;

  always_comb begin
    isl_onehot = '0;
    isl_onehot[cmd_island] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp_meta <= 1'b0;
      comp_s    <= 1'b0;
    end else begin
      comp_meta <= comp_in;
      comp_s    <= comp_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_count    <= '0;
      rsp_timeout  <= 1'b0;
      island_en    <= '0;
      dec_v_addr   <= '0;
      dec_h_addr   <= '0;
      gate_mux_en  <= 1'b0;
      drain_sel_en <= 1'b0;
      prog_sw_en   <= 1'b0;
      vinj_pulse   <= 1'b0;
      meas_en      <= 1'b0;
      op_q         <= 1'b0;
      tout_q       <= 1'b0;
      pulse_cnt    <= '0;
      settle_q     <= '0;
      settle_cnt   <= '0;
      meas_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready    <= 1'b0;
            op_q         <= cmd_op;
            pulse_cnt    <= cmd_pulse;
            settle_q     <= cmd_settle;
            settle_cnt   <= cmd_settle;
            island_en    <= isl_onehot;
            dec_v_addr   <= cmd_row;
            dec_h_addr   <= cmd_col;
            gate_mux_en  <= 1'b1;
            drain_sel_en <= 1'b1;
            prog_sw_en   <= cmd_op;
            state        <= S_ROUTE;
          end
        end
        S_ROUTE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end else if (op_q && (pulse_cnt != '0)) begin
            vinj_pulse <= 1'b1;
            state      <= S_PULSE;
          end else begin
            prog_sw_en <= 1'b0;
            settle_cnt <= settle_q;
            state      <= S_SWAP;
          end
        end
        S_PULSE: begin
          // pulse_cnt holds the cycles still owed including the current one
          if (pulse_cnt != PULSE_W'(1)) begin
            pulse_cnt <= pulse_cnt - PULSE_W'(1);
          end else begin
            vinj_pulse <= 1'b0;
            prog_sw_en <= 1'b0;
            settle_cnt <= settle_q;
            state      <= S_SWAP;
          end
        end
        S_SWAP: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end else begin
            meas_en  <= 1'b1;
            meas_cnt <= '0;
            state    <= S_MEAS;
          end
        end
        S_MEAS: begin
          if (comp_s || (&meas_cnt)) begin
            tout_q       <= ~comp_s;
            meas_en      <= 1'b0;
            island_en    <= '0;
            dec_v_addr   <= '0;
            dec_h_addr   <= '0;
            gate_mux_en  <= 1'b0;
            drain_sel_en <= 1'b0;
            state        <= S_RELEASE;
          end else begin
            meas_cnt <= meas_cnt + MEAS_W'(1);
          end
        end
        S_RELEASE: begin
          rsp_count   <= meas_cnt;
          rsp_timeout <= tout_q;
          rsp_valid   <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Randomized bench for fg_prog_sequencer against a transaction-level timing/result model.
module tb_fg_prog_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [0:0]  cmd_island = '0;
  logic [1:0]  cmd_row = '0;
  logic [2:0]  cmd_col = '0;
  logic        cmd_op = 1'b0;
  logic [15:0] cmd_pulse = '0;
  logic [7:0]  cmd_settle = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_count;
  logic        rsp_timeout;
  logic [1:0]  island_en;
  logic [1:0]  dec_v_addr;
  logic [2:0]  dec_h_addr;
  logic        gate_mux_en, drain_sel_en, prog_sw_en, vinj_pulse, meas_en;
  logic        comp_in = 1'b0;

  int checks = 0;
  int failures = 0;

  // Shared between driver and monitor: command under test and observed activity
  bit       busy = 1'b0;
  int       dly = 0;            // -1: comparator high before MEAS, -2: never, else MEAS cycle index
  int       e_isl, e_row, e_col, e_op;
  int       pre, vcnt, mcyc;
  bit       meas_seen;

  fg_prog_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_island(cmd_island), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_op(cmd_op), .cmd_pulse(cmd_pulse), .cmd_settle(cmd_settle),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_count(rsp_count), .rsp_timeout(rsp_timeout),
    .island_en(island_en), .dec_v_addr(dec_v_addr), .dec_h_addr(dec_h_addr),
    .gate_mux_en(gate_mux_en), .drain_sel_en(drain_sel_en), .prog_sw_en(prog_sw_en),
    .vinj_pulse(vinj_pulse), .meas_en(meas_en), .comp_in(comp_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants and activity counters; also plays the cell's comparator.
  always @(negedge clk) begin
    if (!busy) begin
      pre = 0; vcnt = 0; mcyc = 0; meas_seen = 1'b0;
      comp_in = 1'b0;
    end else begin
      check("ready_while_busy", cmd_ready, 0);
      check("pulse_meas_excl", vinj_pulse & meas_en, 0);
      if (vinj_pulse || meas_en) begin
        check("island_en", island_en, 32'(1) << e_isl);
        check("v_addr", dec_v_addr, e_row);
        check("h_addr", dec_h_addr, e_col);
        check("gate_mux_en", gate_mux_en, 1);
        check("drain_sel_en", drain_sel_en, 1);
      end
      if (vinj_pulse) begin
        vcnt++;
        check("prog_sw_in_pulse", prog_sw_en, 1);
      end
      if (meas_en) begin
        check("prog_sw_in_meas", prog_sw_en, 0);
        if (mcyc == dly) comp_in = 1'b1;
        mcyc++;
        meas_seen = 1'b1;
      end else if (!meas_seen) begin
        pre++;
        if (dly == -1) comp_in = 1'b1;
      end else begin
        comp_in = 1'b0;
      end
    end
  end

  task automatic issue(input int isl, input int row, input int col, input int op,
                       input int pulse, input int settle, input int d);
    int n;
    @(negedge clk);
    cmd_island = 1'(isl); cmd_row = 2'(row); cmd_col = 3'(col);
    cmd_op = 1'(op); cmd_pulse = 16'(pulse); cmd_settle = 8'(settle);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_accept_wait", n < 100, 1);
    e_isl = isl; e_row = row; e_col = col; e_op = op; dly = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    busy = 1'b1;
  endtask

  task automatic run_cmd(input int isl, input int row, input int col, input int op,
                         input int pulse, input int settle, input int d, input int hold);
    int n, exp_cnt, exp_to, exp_vinj;
    exp_vinj = op ? pulse : 0;
    exp_to   = (d == -2) ? 1 : 0;
    exp_cnt  = (d == -1) ? 0 : (d == -2) ? 32'hFFFF : d + 2;
    issue(isl, row, col, op, pulse, settle, d);
    n = 0;
    while (!rsp_valid && n < 70000) begin @(negedge clk); n++; end
    check("rsp_wait", n < 70000, 1);
    check("pre_meas_cycles", pre, 2 * (settle + 1) + exp_vinj);
    check("vinj_cycles", vcnt, exp_vinj);
    check("meas_cycles", mcyc, exp_cnt + 1);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_count", rsp_count, exp_cnt);
      check("hold_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_count", rsp_count, exp_cnt);
    check("rsp_timeout", rsp_timeout, exp_to);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    busy = 1'b0;
    @(negedge clk);
    check("rsp_dropped", rsp_valid, 0);
    check("ready_lag", cmd_ready, 0);
    check("routing_released", {island_en, dec_v_addr, dec_h_addr, gate_mux_en, drain_sel_en, prog_sw_en}, 0);
    @(negedge clk);
    check("ready_back", cmd_ready, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_count, rsp_timeout, island_en, dec_v_addr,
          dec_h_addr, gate_mux_en, drain_sel_en, prog_sw_en, vinj_pulse, meas_en}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);

    // directed cases
    run_cmd(1, 2, 5, 0, 0, 3, 10, 0);     // plain read, comparator 10 cycles into MEAS
    run_cmd(0, 1, 3, 1, 100, 0, 4, 1);    // 100-cycle injection
    run_cmd(1, 3, 7, 1, 0, 2, 6, 0);      // inject with zero pulse
    run_cmd(0, 0, 0, 0, 0, 0, -1, 0);     // comparator already high
    run_cmd(1, 0, 6, 0, 0, 1, 3, 20);     // 20 cycles of response backpressure
    run_cmd(0, 2, 1, 0, 0, 0, -2, 2);     // saturating measurement

    // reset while pulsing
    issue(1, 1, 4, 1, 200, 2, 5);
    n = 0;
    while (!vinj_pulse && n < 50) begin @(negedge clk); n++; end
    check("pulse_started", vinj_pulse, 1);
    @(posedge clk); #1;
    busy = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {cmd_ready, rsp_valid, island_en, dec_v_addr, dec_h_addr,
          gate_mux_en, drain_sel_en, prog_sw_en, vinj_pulse, meas_en}, 0);
    repeat (3) begin
      @(negedge clk);
      check("ready_in_reset", cmd_ready, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_post_abort", cmd_ready, 1);
    check("no_residual_rsp", rsp_valid, 0);

    // randomized traffic
    for (int t = 0; t < 16; t++) begin
      int op, pulse, d;
      op    = int'($urandom_range(0, 1));
      pulse = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 150));
      d     = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 40));
      run_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              op, pulse, int'($urandom_range(0, 9)), d, int'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
